hazard_pipe_regs: RTL and testbench
===================================

// Module: hazard_pipe_regs
// PURPOSE
//  Pipeline-register bank for the 5-stage MIPS core: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Consumes hazard-unit controls (stall_f, stall_d, flush_e) plus branch-taken flush (flush_d).
//  Produces the stage-tagged register addresses and write-control bits the hazard unit reads.
//  Sits between fetch/decode datapath and hazard logic; carries control/addresses only, no ALU data.
// PARAMETERS
//  ADDR_W    32            PC / instruction width
//  REG_W     5             register-file address width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       async active-low reset
//  stall_f        in   1       hold PC register
//  stall_d        in   1       hold IF/ID register
//  flush_d        in   1       branch taken: clear IF/ID
//  flush_e        in   1       insert bubble into ID/EX
//  pc_next        in   ADDR_W  next PC from PC-select mux
//  instr_f        in   ADDR_W  fetched instruction
//  pc_plus4_f     in   ADDR_W  fetch PC+4
//  ra_d, rb_d     in   REG_W   decode source registers
//  write_reg_d    in   REG_W   decode destination (post RegDst)
//  reg_write_d    in   1       decode RegWrite
//  mem_to_reg_d   in   1       decode MemToReg
//  mem_write_d    in   1       decode MemWrite
//  pc_f           out  ADDR_W  current fetch PC
//  instr_d        out  ADDR_W  IF/ID instruction
//  pc_plus4_d     out  ADDR_W  IF/ID PC+4
//  ra_e, rb_e     out  REG_W   ID/EX source registers
//  write_reg_e/m/w out REG_W   destination per stage
//  reg_write_e/m/w out 1       RegWrite per stage
//  mem_to_reg_e/m/w out 1      MemToReg per stage
//  mem_write_e/m  out  1       MemWrite per stage
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc_f=RESET_PC; every other output 0 (all stages = bubble).
//  - All registers update on rising clk; latency one cycle per stage, D->E->M->W.
//  - PC: stall_f=1 holds pc_f; else pc_f<=pc_next.
//  - IF/ID priority: stall_d > flush_d > load. stall_d=1 holds instr_d/pc_plus4_d even if
//    flush_d=1 (branch resolves after stall clears). flush_d=1,stall_d=0 -> instr_d=0 (nop), pc_plus4_d=0.
//  - ID/EX: flush_e=1 -> bubble: ra_e=rb_e=write_reg_e=0, reg_write_e=mem_to_reg_e=mem_write_e=0.
//    Else loads *_d. ID/EX never stalls.
//  - EX/MEM, MEM/WB: unconditional advance every cycle; no stall/flush inputs.
//  - Bubble must never assert reg_write or mem_write in any downstream stage.
//  - write_reg=0 with reg_write=1 passes through unchanged; $zero filtering is the hazard unit's job.
//  - Reset mid-operation: all in-flight stages discarded immediately, no pending writes survive.
//  - stall_f/stall_d/flush_e asserted together (load-use/branch stall): PC and IF/ID hold,
//    bubble enters E, older instructions drain normally.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs stall_cnt[31:0], flush_cnt[31:0]; stall_cnt +1 each cycle
//    stall_d=1, flush_cnt +1 each cycle flush_d=1 (not masked by stall_d) or flush_e=1 (one count
//    if both); both saturate at 32'hFFFF_FFFF; reset to 0.
//  Undefined: ports and counters absent; no other behaviour change.
// STRUCTURE
//  Package mips_pipe_pkg: ctrl_t struct {reg_write, mem_to_reg, mem_write}, REG_W, ADDR_W,
//    RESET_PC default, NOP_INSTR = 32'h0000_0000.
//  Sub-module pipe_stage_reg #(W, RST_VAL): en/clr register, clr beats load, en=0 holds;
//    instantiated per stage (IF/ID en=~stall_d clr=flush_d; ID/EX clr=flush_e; EX/MEM,MEM/WB en=1).
// TESTING
//  - Reset: rst_n=0 async mid-cycle -> pc_f=RESET_PC, all reg_write_*/mem_write_*=0 before next edge.
//  - Flow: write_reg_d=5, reg_write_d=1 at cycle 0 -> write_reg_e=5 @1, _m=5 @2, _w=5 @3.
//  - Load-use: stall_f=stall_d=flush_e=1 one cycle, pc_next=0x14 -> pc_f holds 0x10, instr_d held,
//    reg_write_e=0, write_reg_e=0; next cycle normal flow resumes.
//  - Branch: flush_d=1, stall_d=0, instr_f=0x2002_0001 -> instr_d=0, pc_plus4_d=0.
//  - Priority: flush_d=1 and stall_d=1 -> instr_d keeps prior value 0x8C43_0004.
//  - HAZARD_STATS_EN: 3 stall cycles + 2 flush_e cycles -> stall_cnt=3, flush_cnt=2;
//    preload near max -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and defaults for the MIPS pipeline-register bank.
// ctrl_t carries the per-instruction write controls that travel with each stage.
package mips_pipe_pkg;

    localparam int          ADDR_W    = 32;
    localparam int          REG_W     = 5;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // All-zero control word: a bubble that never writes registers or memory.
    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register with hold (en=0) and synchronous clear to zero (clr=1).
// A held stage ignores clr, so a stall always wins over a flush.
module pipe_stage_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = clr_i ? '0 : d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB control/address registers for the 5-stage core.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_pipe_regs #(
    parameter int                ADDR_W   = mips_pipe_pkg::ADDR_W,
    parameter int                REG_W    = mips_pipe_pkg::REG_W,
    parameter logic [ADDR_W-1:0] RESET_PC = mips_pipe_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_f,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              flush_e,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic [ADDR_W-1:0] instr_f,
    input  logic [ADDR_W-1:0] pc_plus4_f,
    input  logic [REG_W-1:0]  ra_d,
    input  logic [REG_W-1:0]  rb_d,
    input  logic [REG_W-1:0]  write_reg_d,
    input  logic              reg_write_d,
    input  logic              mem_to_reg_d,
    input  logic              mem_write_d,
    output logic [ADDR_W-1:0] pc_f,
    output logic [ADDR_W-1:0] instr_d,
    output logic [ADDR_W-1:0] pc_plus4_d,
    output logic [REG_W-1:0]  ra_e,
    output logic [REG_W-1:0]  rb_e,
    output logic [REG_W-1:0]  write_reg_e,
    output logic [REG_W-1:0]  write_reg_m,
    output logic [REG_W-1:0]  write_reg_w,
    output logic              reg_write_e,
    output logic              reg_write_m,
    output logic              reg_write_w,
    output logic              mem_to_reg_e,
    output logic              mem_to_reg_m,
    output logic              mem_to_reg_w,
    output logic              mem_write_e,
    output logic              mem_write_m
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    import mips_pipe_pkg::*;

    localparam int IFID_W = 2 * ADDR_W;
    localparam int IDEX_W = 3 * REG_W + CTRL_W;
    localparam int EXMM_W = REG_W + CTRL_W;
    // mem_write is consumed in MEM, so WB only carries reg_write and mem_to_reg.
    localparam int MMWB_W = REG_W + 2;

    localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR[ADDR_W-1:0], {ADDR_W{1'b0}}};

    ctrl_t ctrl_d;
    ctrl_t ctrl_e;
    ctrl_t ctrl_m;

    logic [IFID_W-1:0] ifid_dat;
    logic [IDEX_W-1:0] idex_dat;
    logic [EXMM_W-1:0] exmm_dat;
    logic [MMWB_W-1:0] mmwb_dat;

    always_comb begin
        ctrl_d            = bubble_ctrl();
        ctrl_d.reg_write  = reg_write_d;
        ctrl_d.mem_to_reg = mem_to_reg_d;
        ctrl_d.mem_write  = mem_write_d;
    end

    pipe_stage_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (~stall_f),
        .clr_i (1'b0),
        .d_i   (pc_next),
        .q_o   (pc_f)
    );

    // Flush clears to all-zero, which is the NOP encoding.
    pipe_stage_reg #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (~stall_d),
        .clr_i (flush_d),
        .d_i   ({instr_f, pc_plus4_f}),
        .q_o   (ifid_dat)
    );

    assign instr_d    = ifid_dat[IFID_W-1:ADDR_W];
    assign pc_plus4_d = ifid_dat[ADDR_W-1:0];

    pipe_stage_reg #(.W(IDEX_W), .RST_VAL('0)) u_idex (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (1'b1),
        .clr_i (flush_e),
        .d_i   ({ra_d, rb_d, write_reg_d, ctrl_d}),
        .q_o   (idex_dat)
    );

    assign ra_e        = idex_dat[IDEX_W-1 -: REG_W];
    assign rb_e        = idex_dat[IDEX_W-REG_W-1 -: REG_W];
    assign write_reg_e = idex_dat[CTRL_W +: REG_W];
    assign ctrl_e      = ctrl_t'(idex_dat[CTRL_W-1:0]);

    assign reg_write_e  = ctrl_e.reg_write;
    assign mem_to_reg_e = ctrl_e.mem_to_reg;
    assign mem_write_e  = ctrl_e.mem_write;

    pipe_stage_reg #(.W(EXMM_W), .RST_VAL('0)) u_exmm (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (1'b1),
        .clr_i (1'b0),
        .d_i   ({write_reg_e, ctrl_e}),
        .q_o   (exmm_dat)
    );

    assign write_reg_m  = exmm_dat[CTRL_W +: REG_W];
    assign ctrl_m       = ctrl_t'(exmm_dat[CTRL_W-1:0]);
    assign reg_write_m  = ctrl_m.reg_write;
    assign mem_to_reg_m = ctrl_m.mem_to_reg;
    assign mem_write_m  = ctrl_m.mem_write;

    pipe_stage_reg #(.W(MMWB_W), .RST_VAL('0)) u_mmwb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (1'b1),
        .clr_i (1'b0),
        .d_i   ({write_reg_m, ctrl_m.reg_write, ctrl_m.mem_to_reg}),
        .q_o   (mmwb_dat)
    );

    assign write_reg_w  = mmwb_dat[MMWB_W-1:2];
    assign reg_write_w  = mmwb_dat[1];
    assign mem_to_reg_w = mmwb_dat[0];

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // A cycle with both flush_d and flush_e counts once; flush_d counts even while stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((flush_d || flush_e) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Directed bench for hazard_pipe_regs: reset, flow, load-use stall, branch flush, priority.
// Counter checks are included when HAZARD_STATS_EN is defined.
module tb_hazard_pipe_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [31:0] pc_next, instr_f, pc_plus4_f;
    logic [4:0]  ra_d, rb_d, write_reg_d;
    logic        reg_write_d, mem_to_reg_d, mem_write_d;
    logic [31:0] pc_f, instr_d, pc_plus4_d;
    logic [4:0]  ra_e, rb_e, write_reg_e, write_reg_m, write_reg_w;
    logic        reg_write_e, reg_write_m, reg_write_w;
    logic        mem_to_reg_e, mem_to_reg_m, mem_to_reg_w;
    logic        mem_write_e, mem_write_m;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_pipe_regs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .pc_next      (pc_next),
        .instr_f      (instr_f),
        .pc_plus4_f   (pc_plus4_f),
        .ra_d         (ra_d),
        .rb_d         (rb_d),
        .write_reg_d  (write_reg_d),
        .reg_write_d  (reg_write_d),
        .mem_to_reg_d (mem_to_reg_d),
        .mem_write_d  (mem_write_d),
        .pc_f         (pc_f),
        .instr_d      (instr_d),
        .pc_plus4_d   (pc_plus4_d),
        .ra_e         (ra_e),
        .rb_e         (rb_e),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (write_reg_m),
        .write_reg_w  (write_reg_w),
        .reg_write_e  (reg_write_e),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_to_reg_m (mem_to_reg_m),
        .mem_to_reg_w (mem_to_reg_w),
        .mem_write_e  (mem_write_e),
        .mem_write_m  (mem_write_m)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall_f = 0; stall_d = 0; flush_d = 0; flush_e = 0;
        pc_next = 0; instr_f = 0; pc_plus4_f = 0;
        ra_d = 0; rb_d = 0; write_reg_d = 0;
        reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0;

        #12;
        chk("rst_pc_f", pc_f, 32'h0);
        chk("rst_instr_d", instr_d, 32'h0);
        chk("rst_reg_write_ewm", {29'b0, reg_write_e, reg_write_m, reg_write_w}, 32'h0);
        chk("rst_mem_write_em", {30'b0, mem_write_e, mem_write_m}, 32'h0);
        chk("rst_write_reg_e", {27'b0, write_reg_e}, 32'h0);
        #1 rst_n = 1'b1;

        // Cycle 0: lw-like instruction, dest 5
        pc_next = 32'h04; instr_f = 32'h8C43_0004; pc_plus4_f = 32'h04;
        ra_d = 5'd2; rb_d = 5'd3; write_reg_d = 5'd5;
        reg_write_d = 1; mem_to_reg_d = 1; mem_write_d = 0;
        step();
        chk("c1_pc_f", pc_f, 32'h04);
        chk("c1_instr_d", instr_d, 32'h8C43_0004);
        chk("c1_write_reg_e", {27'b0, write_reg_e}, 32'd5);
        chk("c1_ctrl_e", {29'b0, reg_write_e, mem_to_reg_e, mem_write_e}, 32'b110);
        chk("c1_ra_rb_e", {22'b0, ra_e, rb_e}, {22'b0, 5'd2, 5'd3});

        // Store-like instruction, dest 7
        pc_next = 32'h10; pc_plus4_f = 32'h10;
        ra_d = 5'd1; rb_d = 5'd4; write_reg_d = 5'd7;
        reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 1;
        step();
        chk("c2_pc_f", pc_f, 32'h10);
        chk("c2_write_reg_m", {27'b0, write_reg_m}, 32'd5);
        chk("c2_ctrl_m", {29'b0, reg_write_m, mem_to_reg_m, mem_write_m}, 32'b110);
        chk("c2_ctrl_e", {29'b0, reg_write_e, mem_to_reg_e, mem_write_e}, 32'b001);
        chk("c2_pc_plus4_d", pc_plus4_d, 32'h10);

        // Load-use stall: PC and IF/ID hold, bubble into E, older drain
        stall_f = 1; stall_d = 1; flush_e = 1;
        pc_next = 32'h14; instr_f = 32'h1111_1111; pc_plus4_f = 32'h14;
        write_reg_d = 5'd9; reg_write_d = 1; mem_write_d = 0;
        step();
        chk("lu_pc_f", pc_f, 32'h10);
        chk("lu_instr_d", instr_d, 32'h8C43_0004);
        chk("lu_pc_plus4_d", pc_plus4_d, 32'h10);
        chk("lu_reg_write_e", {31'b0, reg_write_e}, 32'h0);
        chk("lu_write_reg_e", {27'b0, write_reg_e}, 32'h0);
        chk("lu_mem_write_m", {31'b0, mem_write_m}, 32'h1);
        chk("lu_write_reg_m", {27'b0, write_reg_m}, 32'd7);
        chk("lu_w", {26'b0, write_reg_w, reg_write_w}, {26'b0, 5'd5, 1'b1});

        // Resume; dest $zero with reg_write=1 must pass through untouched
        stall_f = 0; stall_d = 0; flush_e = 0;
        instr_f = 32'h2002_0001; pc_plus4_f = 32'h14;
        write_reg_d = 5'd0; reg_write_d = 1;
        step();
        chk("rs_pc_f", pc_f, 32'h14);
        chk("rs_instr_d", instr_d, 32'h2002_0001);
        chk("rs_e_zero", {26'b0, write_reg_e, reg_write_e}, 32'h1);
        chk("rs_m_bubble", {30'b0, reg_write_m, mem_write_m}, 32'h0);
        chk("rs_w", {26'b0, write_reg_w, reg_write_w}, {26'b0, 5'd7, 1'b0});

        // Branch taken: IF/ID cleared
        flush_d = 1; pc_next = 32'h18; pc_plus4_f = 32'h18;
        reg_write_d = 0;
        step();
        chk("br_instr_d", instr_d, 32'h0);
        chk("br_pc_plus4_d", pc_plus4_d, 32'h0);
        chk("br_pc_f", pc_f, 32'h18);
        chk("br_m_zero", {26'b0, write_reg_m, reg_write_m}, 32'h1);
        chk("br_w_bubble", {31'b0, reg_write_w}, 32'h0);

        flush_d = 0; instr_f = 32'h8C43_0004; pc_plus4_f = 32'h1C;
        step();
        chk("rl_instr_d", instr_d, 32'h8C43_0004);
        chk("rl_w_zero", {26'b0, write_reg_w, reg_write_w}, 32'h1);

        // Stall beats flush on IF/ID
        flush_d = 1; stall_d = 1; stall_f = 1;
        instr_f = 32'hDEAD_BEEF; pc_plus4_f = 32'h20;
        step();
        chk("pr_instr_d", instr_d, 32'h8C43_0004);
        chk("pr_pc_plus4_d", pc_plus4_d, 32'h1C);

        stall_d = 0; stall_f = 0;
        step();
        chk("pr_release_instr_d", instr_d, 32'h0);

        // Mid-cycle async reset discards in-flight writes
        flush_d = 0; pc_next = 32'h40;
        write_reg_d = 5'd3; reg_write_d = 1; mem_write_d = 1;
        step();
        step();
        chk("pre_rst_m", {30'b0, reg_write_m, mem_write_m}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pc_f", pc_f, 32'h0);
        chk("ar_reg_write", {29'b0, reg_write_e, reg_write_m, reg_write_w}, 32'h0);
        chk("ar_mem_write", {30'b0, mem_write_e, mem_write_m}, 32'h0);
        chk("ar_write_reg_e", {27'b0, write_reg_e}, 32'h0);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_m", {30'b0, reg_write_m, mem_write_m}, 32'h0);
        chk("post_rst_e", {30'b0, reg_write_e, mem_write_e}, 32'b11);

`ifdef HAZARD_STATS_EN
        reg_write_d = 0; mem_write_d = 0;
        chk("st_init", stall_cnt, 32'd0);
        stall_d = 1;
        step(); step(); step();
        stall_d = 0; flush_e = 1;
        step(); step();
        flush_e = 0;
        step();
        chk("st_stall_cnt", stall_cnt, 32'd3);
        chk("st_flush_cnt", flush_cnt, 32'd2);
        flush_d = 1; flush_e = 1;
        step();
        flush_d = 0; flush_e = 0;
        chk("st_flush_both", flush_cnt, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
